mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Consumer side of the EX/MEM pipeline register: the MEM stage of the 16-bit CPU.
//  Turns registered load/store controls into a multi-cycle SRAM access, stalls the pipeline upstream, and drives the MEM/WB register.
//  Non-memory instructions pass through with one register stage of latency.
// PARAMETERS
//  WAIT_CYCLES  1   extra SRAM strobe cycles per access, 0..15; ACCESS lasts WAIT_CYCLES+1 cycles
//  DATA_W       16  data and address width
// PORTS
//  CLK          in   1   single clock; all state changes on posedge
//  RST          in   1   asynchronous, active-low reset
//  regwrite_i   in   1   EX/MEM: write register file
//  memtoreg_i   in   1   EX/MEM: writeback selects load data
//  memread_i    in   1   EX/MEM: load
//  memwrite_i   in   1   EX/MEM: store
//  memdata_i    in   16  EX/MEM: store data
//  regdst_i     in   4   EX/MEM: destination register; 4'b1111 = none
//  alures_i     in   16  EX/MEM: ALU result / memory address
//  ram_addr_o   out  16  SRAM address
//  ram_wdata_o  out  16  SRAM write data
//  ram_rdata_i  in   16  SRAM read data
//  ram_en_n_o   out  1   SRAM chip enable, active low
//  ram_oe_n_o   out  1   SRAM output enable, active low
//  ram_we_n_o   out  1   SRAM write enable, active low
//  stall_o      out  1   pipeline hold; when high, PC, IF/ID, ID/EX and EX/MEM must hold their contents
//  regwrite_o   out  1   MEM/WB: write register file
//  memtoreg_o   out  1   MEM/WB: memtoreg, passed through
//  regdst_o     out  4   MEM/WB: destination register
//  wbdata_o     out  16  MEM/WB: load data or ALU result
// BEHAVIOUR
//  Reset (async, immediate):
//   - State goes to IDLE; ram_en_n/oe_n/we_n = 1; stall_o = 0.
//   - regwrite_o = 0, memtoreg_o = 0, regdst_o = 4'b1111, wbdata_o = 0.
//   - ram_addr_o = 0, ram_wdata_o = 0.
//   - An access in flight is aborted mid-operation; it produces no writeback.
//  FSM states: IDLE, ACCESS, RECOVER.
//  IDLE, no memory op (memread_i = memwrite_i = 0):
//   - stall_o = 0; strobes inactive.
//   - Each edge loads MEM/WB: regwrite/memtoreg/regdst from inputs, wbdata_o <= alures_i. Latency 1 cycle.
//  IDLE, memory op:
//   - stall_o = 1 combinationally, in the same cycle.
//   - Edge: latch ram_addr_o <= alures_i, ram_wdata_o <= memdata_i, op type, regdst, regwrite, memtoreg.
//   - Edge: wait counter <= WAIT_CYCLES; MEM/WB loads a bubble (regwrite_o = 0, regdst_o = 4'b1111).
//   - Next state ACCESS.
//  ACCESS:
//   - stall_o = 1; ram_en_n = 0; oe_n = 0 for a read, we_n = 0 for a write.
//   - Address and data stay stable; counter decrements each cycle.
//   - When counter == 0, at the edge:
//     - read: wbdata_o <= ram_rdata_i, regwrite_o/regdst_o/memtoreg_o <= latched values.
//     - write: wbdata_o <= latched address, regwrite_o <= latched regwrite.
//     - Go to RECOVER.
//  RECOVER:
//   - Strobes inactive; address and data held one more cycle for SRAM hold time; stall_o = 0.
//   - EX/MEM inputs are ignored: they still show the completed instruction.
//   - Edge loads a MEM/WB bubble; go to IDLE.
//  Timing and boundary rules:
//   - Memory op total: WAIT_CYCLES+3 cycles. stall_o is high for WAIT_CYCLES+2 cycles.
//   - The result is visible on MEM/WB for exactly 1 cycle (RECOVER).
//   - memread_i and memwrite_i both set: the write wins, no read strobe.
//   - A memory op arriving the cycle after RECOVER starts with no gap.
//   - WAIT_CYCLES = 0: ACCESS lasts 1 cycle.
//   - Read data is sampled only at the final ACCESS edge.
//   - Exactly one SRAM strobe (oe_n or we_n) is active at a time, and only in ACCESS.
// STRUCTURE
//  Shared package:
//   - State encoding (IDLE = 2'd0, ACCESS = 2'd1, RECOVER = 2'd2).
//   - REG_NONE = 4'b1111; DATA_W.
//  Sub-module: mem_wait_timer (load / decrement / zero flag, 4-bit). Everything else is inline.
// TESTING
//  1. Reset with RST = 0 mid-ACCESS -> strobes go to 1 with no clock edge; stall_o = 0; regdst_o = 4'hF.
//  2. ALU op alures_i = 16'h1234, regdst_i = 3, regwrite_i = 1 -> next cycle wbdata_o = 16'h1234, regdst_o = 3, stall_o never high.
//  3. Load from addr 16'h0040, SRAM returns 16'hBEEF, WAIT_CYCLES = 1 -> stall_o high 3 cycles, oe_n low 2 cycles, wbdata_o = 16'hBEEF for 1 cycle.
//  4. Store 16'hA5A5 to 16'h0100 -> we_n low for WAIT_CYCLES+1 cycles; addr/data stable through RECOVER; regwrite_o = 0.
//  5. Back-to-back load then store -> second access starts the cycle after RECOVER; no duplicate access of the first op.
//  6. memread_i = memwrite_i = 1, and WAIT_CYCLES = 0 build -> write-only strobe; stall_o high exactly 2 cycles.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMER_W = 4;

    localparam logic [3:0] REG_NONE = 4'b1111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRecover = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter that paces the SRAM strobe phase: load, decrement, zero flag.
module mem_wait_timer
    import mem_access_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM stage: turns EX/MEM load/store controls into a paced SRAM access and drives MEM/WB.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [3:0]        regdst_i,
    input  logic [DATA_W-1:0] alures_i,
    output logic [DATA_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_en_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic              stall_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [3:0]        regdst_o,
    output logic [DATA_W-1:0] wbdata_o
);

    import mem_access_ctrl_pkg::*;

    localparam logic [TIMER_W-1:0] WaitLoad = TIMER_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic              is_write_q, is_write_d;
    logic              lat_regwrite_q, lat_regwrite_d;
    logic              lat_memtoreg_q, lat_memtoreg_d;
    logic [3:0]        lat_regdst_q, lat_regdst_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [3:0]        regdst_q, regdst_d;
    logic              en_n_q, en_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;

    logic mem_op;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    assign mem_op = memread_i | memwrite_i;

    mem_wait_timer u_wait_timer (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (timer_load),
        .dec_i      (timer_dec),
        .load_val_i (WaitLoad),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wbdata_d       = wbdata_q;
        is_write_d     = is_write_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_regdst_d   = lat_regdst_q;
        regwrite_d     = regwrite_q;
        memtoreg_d     = memtoreg_q;
        regdst_d       = regdst_q;
        en_n_d         = en_n_q;
        oe_n_d         = oe_n_q;
        we_n_d         = we_n_q;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    addr_d         = alures_i;
                    wdata_d        = memdata_i;
                    is_write_d     = memwrite_i;
                    lat_regwrite_d = regwrite_i;
                    lat_memtoreg_d = memtoreg_i;
                    lat_regdst_d   = regdst_i;
                    regwrite_d     = 1'b0;
                    memtoreg_d     = 1'b0;
                    regdst_d       = REG_NONE;
                    timer_load     = 1'b1;
                    // A write takes priority when both read and write are requested.
                    en_n_d         = 1'b0;
                    oe_n_d         = memwrite_i;
                    we_n_d         = ~memwrite_i;
                    state_d        = StAccess;
                end else begin
                    regwrite_d = regwrite_i;
                    memtoreg_d = memtoreg_i;
                    regdst_d   = regdst_i;
                    wbdata_d   = alures_i;
                end
            end
            StAccess: begin
                if (timer_zero) begin
                    wbdata_d   = is_write_q ? addr_q : ram_rdata_i;
                    regwrite_d = lat_regwrite_q;
                    memtoreg_d = lat_memtoreg_q;
                    regdst_d   = lat_regdst_q;
                    en_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    state_d    = StRecover;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StRecover: begin
                // Address and data stay put for SRAM hold time; EX/MEM still shows this op.
                regwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                regdst_d   = REG_NONE;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            wdata_q        <= '0;
            wbdata_q       <= '0;
            is_write_q     <= 1'b0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_regdst_q   <= REG_NONE;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            regdst_q       <= REG_NONE;
            en_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wbdata_q       <= wbdata_d;
            is_write_q     <= is_write_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_regdst_q   <= lat_regdst_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            regdst_q       <= regdst_d;
            en_n_q         <= en_n_d;
            oe_n_q         <= oe_n_d;
            we_n_q         <= we_n_d;
        end
    end

    // Gated by reset so the upstream pipeline is released while reset is held.
    assign stall_o = RST & (((state_q == StIdle) & mem_op) | (state_q == StAccess));

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_en_n_o  = en_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;
    assign regwrite_o  = regwrite_q;
    assign memtoreg_o  = memtoreg_q;
    assign regdst_o    = regdst_q;
    assign wbdata_o    = wbdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, random traffic against a timeline model,
// reset-abort and zero-wait corner sequences.
module tb_mem_access_ctrl;

    localparam int unsigned W = 1;
    localparam int MaxCyc = 8192;
    localparam int NVec = 8;

    logic CLK = 1'b0;
    logic RST;

    logic        regwrite_i, memtoreg_i, memread_i, memwrite_i;
    logic [15:0] memdata_i, alures_i, ram_addr_o, ram_wdata_o, ram_rdata_i, wbdata_o;
    logic [3:0]  regdst_i, regdst_o;
    logic        ram_en_n_o, ram_oe_n_o, ram_we_n_o, stall_o, regwrite_o, memtoreg_o;

    logic        b_regwrite_i, b_memtoreg_i, b_memread_i, b_memwrite_i;
    logic [15:0] b_memdata_i, b_alures_i, b_ram_addr_o, b_ram_wdata_o, b_wbdata_o;
    logic [3:0]  b_regdst_i, b_regdst_o;
    logic        b_ram_en_n_o, b_ram_oe_n_o, b_ram_we_n_o, b_stall_o, b_regwrite_o, b_memtoreg_o;

    mem_access_ctrl #(.WAIT_CYCLES(W), .DATA_W(16)) u_dut (
        .CLK(CLK), .RST(RST),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .memread_i(memread_i),
        .memwrite_i(memwrite_i), .memdata_i(memdata_i), .regdst_i(regdst_i),
        .alures_i(alures_i), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .ram_en_n_o(ram_en_n_o), .ram_oe_n_o(ram_oe_n_o),
        .ram_we_n_o(ram_we_n_o), .stall_o(stall_o), .regwrite_o(regwrite_o),
        .memtoreg_o(memtoreg_o), .regdst_o(regdst_o), .wbdata_o(wbdata_o)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .DATA_W(16)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .regwrite_i(b_regwrite_i), .memtoreg_i(b_memtoreg_i), .memread_i(b_memread_i),
        .memwrite_i(b_memwrite_i), .memdata_i(b_memdata_i), .regdst_i(b_regdst_i),
        .alures_i(b_alures_i), .ram_addr_o(b_ram_addr_o), .ram_wdata_o(b_ram_wdata_o),
        .ram_rdata_i(16'hC0DE), .ram_en_n_o(b_ram_en_n_o), .ram_oe_n_o(b_ram_oe_n_o),
        .ram_we_n_o(b_ram_we_n_o), .stall_o(b_stall_o), .regwrite_o(b_regwrite_o),
        .memtoreg_o(b_memtoreg_o), .regdst_o(b_regdst_o), .wbdata_o(b_wbdata_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // Behavioural SRAM, 4K words.
    logic [15:0] sram [4096];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
        end else if (!ram_en_n_o && !ram_we_n_o) begin
            sram[ram_addr_o[11:0]] <= ram_wdata_o;
        end
    end
    assign ram_rdata_i = sram[ram_addr_o[11:0]];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int next_issue = 0;
    int last_issue = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle behaviour, built from the transaction rules.
    logic        exp_stall [MaxCyc];
    logic        exp_en_n  [MaxCyc];
    logic        exp_oe_n  [MaxCyc];
    logic        exp_we_n  [MaxCyc];
    logic        exp_rw    [MaxCyc];
    logic        exp_mtr   [MaxCyc];
    logic [3:0]  exp_rd    [MaxCyc];
    logic        exp_res   [MaxCyc];
    logic [15:0] exp_wb    [MaxCyc];
    logic        exp_mem   [MaxCyc];
    logic [15:0] exp_addr  [MaxCyc];
    logic [15:0] exp_wdata [MaxCyc];
    logic [15:0] mm        [4096];

    logic        obs_stall [MaxCyc];
    logic        obs_rw    [MaxCyc];
    logic [3:0]  obs_rd    [MaxCyc];
    logic [15:0] obs_wb    [MaxCyc];

    typedef struct {
        logic        rw, mtr, mr, mw;
        logic [3:0]  rd;
        logic [15:0] alu, md;
        logic [15:0] exp_wb;
        logic        exp_rw;
        logic [3:0]  exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs [NVec];
    int   vec_k [NVec];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        if (chk_en && c < MaxCyc) begin
            chk("stall", 16'(stall_o), 16'(exp_stall[c]));
            chk("ram_en_n", 16'(ram_en_n_o), 16'(exp_en_n[c]));
            chk("ram_oe_n", 16'(ram_oe_n_o), 16'(exp_oe_n[c]));
            chk("ram_we_n", 16'(ram_we_n_o), 16'(exp_we_n[c]));
            chk("regwrite", 16'(regwrite_o), 16'(exp_rw[c]));
            chk("regdst", 16'(regdst_o), 16'(exp_rd[c]));
            if (exp_res[c]) begin
                chk("wbdata", wbdata_o, exp_wb[c]);
                chk("memtoreg", 16'(memtoreg_o), 16'(exp_mtr[c]));
            end
            if (exp_mem[c]) begin
                chk("ram_addr", ram_addr_o, exp_addr[c]);
                chk("ram_wdata", ram_wdata_o, exp_wdata[c]);
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        check_cycle(cyc);
        if (cyc < MaxCyc) begin
            obs_stall[cyc] = stall_o;
            obs_rw[cyc]    = regwrite_o;
            obs_rd[cyc]    = regdst_o;
            obs_wb[cyc]    = wbdata_o;
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic rw, mtr, mr, mw, input logic [3:0] rd,
                         input logic [15:0] alu, md);
        regwrite_i = rw; memtoreg_i = mtr; memread_i = mr; memwrite_i = mw;
        regdst_i = rd; alures_i = alu; memdata_i = md;
    endtask

    task automatic set_out(input int c, input logic rw, mtr, input logic [3:0] rd,
                           input logic [15:0] wb);
        if (c < MaxCyc) begin
            exp_rw[c] = rw; exp_mtr[c] = mtr; exp_rd[c] = rd; exp_wb[c] = wb; exp_res[c] = 1'b1;
        end
    endtask

    task automatic set_mem(input int c, input logic [15:0] a, d);
        if (c < MaxCyc) begin
            exp_mem[c] = 1'b1; exp_addr[c] = a; exp_wdata[c] = d;
        end
    endtask

    // Issue one instruction once the pipeline would accept it, and extend the model timeline.
    task automatic issue(input logic rw, mtr, mr, mw, input logic [3:0] rd,
                         input logic [15:0] alu, md);
        int k;
        int n;
        logic [15:0] res;
        while (cyc < next_issue) step();
        k = cyc;
        last_issue = k;
        drive(rw, mtr, mr, mw, rd, alu, md);
        if (!(mr || mw)) begin
            set_out(k + 1, rw, mtr, rd, alu);
            next_issue = k + 1;
        end else begin
            n = int'(W) + 1;
            if (k + n + 2 < MaxCyc) begin
                exp_stall[k] = 1'b1;
                for (int j = 1; j <= n; j++) begin
                    exp_stall[k + j] = 1'b1;
                    exp_en_n[k + j]  = 1'b0;
                    exp_oe_n[k + j]  = mw;
                    exp_we_n[k + j]  = !mw;
                    set_mem(k + j, alu, md);
                end
            end
            res = mw ? alu : mm[alu[11:0]];
            if (mw) mm[alu[11:0]] = md;
            set_out(k + n + 1, rw, mtr, rd, res);
            set_mem(k + n + 1, alu, md);
            next_issue = k + n + 2;
        end
        step();
    endtask

    task automatic b_op(input string tag, input logic mr, mw, input logic [15:0] alu, md,
                        input logic [15:0] exp_wb, input int exp_oe, exp_we);
        int ns, no, nw, ne;
        bit done;
        ns = 0; no = 0; nw = 0; ne = 0; done = 1'b0;
        b_regwrite_i = mr & ~mw; b_memtoreg_i = mr & ~mw; b_memread_i = mr;
        b_memwrite_i = mw; b_regdst_i = 4'd4; b_alures_i = alu; b_memdata_i = md;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (b_stall_o) ns++;
            if (!b_ram_oe_n_o) no++;
            if (!b_ram_we_n_o) nw++;
            if (!b_ram_en_n_o) ne++;
            if (i == 0) chk({tag, " comb stall"}, 16'(b_stall_o), 16'd1);
            if (!b_stall_o && !done) begin
                done = 1'b1;
                chk({tag, " wbdata"}, b_wbdata_o, exp_wb);
                chk({tag, " addr hold"}, b_ram_addr_o, alu);
                chk({tag, " regwrite"}, 16'(b_regwrite_o), 16'(mr & ~mw));
            end
            @(posedge CLK);
            #1;
            if (done) begin
                b_memread_i = 1'b0; b_memwrite_i = 1'b0; b_regwrite_i = 1'b0;
                b_memtoreg_i = 1'b0; b_regdst_i = 4'hF;
            end
        end
        chk({tag, " stall cycles"}, 16'(ns), 16'd2);
        chk({tag, " en cycles"}, 16'(ne), 16'd1);
        chk({tag, " oe cycles"}, 16'(no), 16'(exp_oe));
        chk({tag, " we cycles"}, 16'(nw), 16'(exp_we));
    endtask

    initial begin
        int kind;
        int r;
        int n;
        logic mr, mw;
        logic [15:0] alu;

        for (int c = 0; c < MaxCyc; c++) begin
            exp_stall[c] = 1'b0; exp_en_n[c] = 1'b1; exp_oe_n[c] = 1'b1; exp_we_n[c] = 1'b1;
            exp_rw[c] = 1'b0; exp_mtr[c] = 1'b0; exp_rd[c] = 4'hF; exp_res[c] = 1'b0;
            exp_wb[c] = '0; exp_mem[c] = 1'b0; exp_addr[c] = '0; exp_wdata[c] = '0;
            obs_stall[c] = 1'b0; obs_rw[c] = 1'b0; obs_rd[c] = 4'h0; obs_wb[c] = '0;
        end
        for (int i = 0; i < 4096; i++) mm[i] = init_val(i);

        //          rw    mtr   mr    mw    rd     alu       md        wb        rw    rd     stall
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  16'h1234, 16'h0000, 16'h1234, 1'b1, 4'd3,  0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hF,  16'h0100, 16'hA5A5, 16'h0100, 1'b0, 4'hF,  3};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hF,  16'h0040, 16'hBEEF, 16'h0040, 1'b0, 4'hF,  3};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  16'h0040, 16'h0000, 16'hBEEF, 1'b1, 4'd5,  3};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hF,  16'h0200, 16'h1357, 16'h0200, 1'b0, 4'hF,  3};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  16'h0100, 16'h0000, 16'hA5A5, 1'b1, 4'd7,  3};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hF,  16'h0300, 16'h2468, 16'h0300, 1'b0, 4'hF,  3};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 4'd9,  0};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 16'h0);
        b_regwrite_i = 1'b0; b_memtoreg_i = 1'b0; b_memread_i = 1'b0; b_memwrite_i = 1'b0;
        b_regdst_i = 4'hF; b_alures_i = '0; b_memdata_i = '0;

        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        chk("reset stall", 16'(stall_o), 16'd0);
        chk("reset en_n", 16'(ram_en_n_o), 16'd1);
        chk("reset oe_n", 16'(ram_oe_n_o), 16'd1);
        chk("reset we_n", 16'(ram_we_n_o), 16'd1);
        chk("reset regwrite", 16'(regwrite_o), 16'd0);
        chk("reset memtoreg", 16'(memtoreg_o), 16'd0);
        chk("reset regdst", 16'(regdst_o), 16'hF);
        chk("reset wbdata", wbdata_o, 16'h0);
        chk("reset addr", ram_addr_o, 16'h0);
        chk("reset wdata", ram_wdata_o, 16'h0);
        #19 RST = 1'b1;
        @(posedge CLK);
        cyc = 1;
        #1;
        next_issue = 1;
        chk_en = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            issue(vecs[i].rw, vecs[i].mtr, vecs[i].mr, vecs[i].mw, vecs[i].rd,
                  vecs[i].alu, vecs[i].md);
            vec_k[i] = last_issue;
        end
        repeat (3) issue(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 16'h0);

        for (int i = 0; i < NVec; i++) begin
            r = vec_k[i] + ((vecs[i].mr || vecs[i].mw) ? int'(W) + 2 : 1);
            chk($sformatf("vec%0d wbdata", i), obs_wb[r], vecs[i].exp_wb);
            chk($sformatf("vec%0d regwrite", i), 16'(obs_rw[r]), 16'(vecs[i].exp_rw));
            chk($sformatf("vec%0d regdst", i), 16'(obs_rd[r]), 16'(vecs[i].exp_rd));
            n = 0;
            while (n < 10 && obs_stall[vec_k[i] + n]) n++;
            chk($sformatf("vec%0d stall cycles", i), 16'(n), 16'(vecs[i].exp_stall));
            if (vecs[i].mr || vecs[i].mw)
                chk($sformatf("vec%0d one-cycle result", i), 16'(obs_rd[r + 1]), 16'hF);
        end

        repeat (300) begin
            kind = $urandom_range(0, 9);
            mr = (kind == 5 || kind == 6 || kind == 9);
            mw = (kind == 7 || kind == 8 || kind == 9);
            alu = (mr || mw) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
            issue(1'($urandom), 1'($urandom), mr, mw, 4'($urandom), alu, 16'($urandom));
        end
        repeat (4) issue(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 16'h0);
        chk_en = 1'b0;

        // Reset in the middle of an access: strobes drop at once and nothing is written back.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0040, 16'h0000);
        @(posedge CLK);
        #3;
        chk("pre-abort oe_n", 16'(ram_oe_n_o), 16'd0);
        RST = 1'b0;
        #1;
        chk("abort en_n", 16'(ram_en_n_o), 16'd1);
        chk("abort oe_n", 16'(ram_oe_n_o), 16'd1);
        chk("abort we_n", 16'(ram_we_n_o), 16'd1);
        chk("abort stall", 16'(stall_o), 16'd0);
        chk("abort regdst", 16'(regdst_o), 16'hF);
        chk("abort regwrite", 16'(regwrite_o), 16'd0);
        chk("abort addr", ram_addr_o, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0, 16'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("abort no writeback", 16'(regwrite_o), 16'd0);
            chk("abort oe idle", 16'(ram_oe_n_o), 16'd1);
        end

        // Zero-wait build: read+write resolves to a write, then a plain read.
        b_op("w0 rdwr", 1'b1, 1'b1, 16'h0055, 16'h7777, 16'h0055, 0, 1);
        b_op("w0 read", 1'b1, 1'b0, 16'h0077, 16'h0000, 16'hC0DE, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
